// File: rtl/mem_rd_sched.sv
// Read-request scheduler: rotates tagged reads across memory read ports and returns
// captured data in order through a credit-protected response FIFO.
module mem_rd_sched #(
  parameter int unsigned NUMRPRT = 4,
  parameter int unsigned BITADDR = 6,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned RDLAT   = 0,
  parameter int unsigned BITTAG  = 4,
  parameter int unsigned FIFODEP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [BITADDR-1:0]        req_adr,
  input  logic [BITTAG-1:0]         req_tag,
  output logic [NUMRPRT-1:0]        read,
  output logic [BITADDR-1:0]        rd_adr [0:NUMRPRT-1],
  input  logic [WIDTH-1:0]          rd_dout [0:NUMRPRT-1],
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [BITTAG-1:0]         rsp_tag,
  output logic [$clog2(FIFODEP):0]  occ
);

  localparam int unsigned AW = $clog2(FIFODEP);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned PW = (NUMRPRT > 1) ? $clog2(NUMRPRT) : 1;
  localparam int unsigned EW = WIDTH + BITTAG;
  localparam bit RDLAT_OK = (RDLAT <= 1);

  logic [PW-1:0]      pptr;
  logic [BITADDR-1:0] adr_q [0:NUMRPRT-1];
  logic [OW-1:0]      wptr;
  logic [OW-1:0]      rptr;
  logic [EW-1:0]      fifo [0:FIFODEP-1];
  logic               accept;
  logic               pop;
  logic               push;
  logic               full;
  logic [EW-1:0]      push_ent;

  // Credit comes only from the registered outstanding count.
  assign req_rdy = rst & (occ < OW'(FIFODEP));
  assign accept  = req_vld & req_rdy;
  assign pop     = rsp_vld & rsp_rdy;
  assign rsp_vld = (wptr != rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign {rsp_tag, rsp_data} = fifo[rptr[AW-1:0]];

  // Issue strobe goes straight to the selected port; idle ports show their last address.
  always_comb begin
    read = '0;
    for (int unsigned p = 0; p < NUMRPRT; p++) begin
      rd_adr[p] = adr_q[p];
      if (accept && (pptr == PW'(p))) begin
        read[p]   = 1'b1;
        rd_adr[p] = req_adr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pptr <= '0;
      for (int unsigned p = 0; p < NUMRPRT; p++) adr_q[p] <= '0;
    end else if (accept) begin
      adr_q[pptr] <= req_adr;
      pptr        <= (pptr == PW'(NUMRPRT - 1)) ? '0 : pptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ <= '0;
    else      occ <= occ + OW'(accept) - OW'(pop);
  end

  if (RDLAT == 0) begin : g_lat0
    assign push     = accept;
    assign push_ent = {req_tag, rd_dout[pptr]};
  end else begin : g_lat1
    logic              pv;
    logic [PW-1:0]     pport;
    logic [BITTAG-1:0] ptag;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv    <= 1'b0;
        pport <= '0;
        ptag  <= '0;
      end else begin
        pv <= accept;
        if (accept) begin
          pport <= pptr;
          ptag  <= req_tag;
        end
      end
    end

    assign push     = pv;
    assign push_ent = {ptag, rd_dout[pport]};
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + OW'(push);
      rptr <= rptr + OW'(pop);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      a_rdlat: assert (RDLAT_OK);
      a_occ:   assert (occ <= OW'(FIFODEP));
      a_push:  assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_mem_rd_sched.sv
// Scoreboard bench for mem_rd_sched: one RDLAT=0 and one RDLAT=1 instance on shared stimulus.
module tb_mem_rd_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld;
  logic [5:0] req_adr;
  logic [3:0] req_tag;
  logic       rsp_rdy;

  logic        req_rdy0, req_rdy1;
  logic [3:0]  read0, read1;
  logic [5:0]  rd_adr0 [0:3];
  logic [5:0]  rd_adr1 [0:3];
  logic [23:0] rd_dout0 [0:3];
  logic [23:0] rd_dout1 [0:3];
  logic        rsp_vld0, rsp_vld1;
  logic [23:0] rsp_data0, rsp_data1;
  logic [3:0]  rsp_tag0, rsp_tag1;
  logic [3:0]  occ0, occ1;

  int checks = 0;
  int errors = 0;

  logic [27:0] sbq [2][$];
  int          occm [2];
  int          pm [2];
  bit          held [2];
  logic [27:0] hent [2];

  always #5 clk = ~clk;

  mem_rd_sched #(.RDLAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy0), .req_adr(req_adr),
    .req_tag(req_tag), .read(read0), .rd_adr(rd_adr0), .rd_dout(rd_dout0),
    .rsp_vld(rsp_vld0), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data0), .rsp_tag(rsp_tag0), .occ(occ0)
  );

  mem_rd_sched #(.RDLAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy1), .req_adr(req_adr),
    .req_tag(req_tag), .read(read1), .rd_adr(rd_adr1), .rd_dout(rd_dout1),
    .rsp_vld(rsp_vld1), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1), .occ(occ1)
  );

  function automatic logic [23:0] memf(input logic [5:0] a);
    memf = {2'b01, a, ~a, 2'b10, a ^ 6'h15, 2'b11};
  endfunction

  // Memory model: garbage on ports not being read, so a wrong port select shows up.
  always_comb begin
    for (int p = 0; p < 4; p++)
      rd_dout0[p] = read0[p] ? memf(rd_adr0[p]) : (24'hBAD000 | 24'(p));
  end

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++)
      rd_dout1[p] <= read1[p] ? memf(rd_adr1[p]) : (24'hBAD100 | 24'(p));
  end

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h exp %0h at %0t", name, d, got, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic rdy, input logic [3:0] rd, input logic [5:0] radr,
                     input logic rv, input logic [23:0] rdat, input logic [3:0] rtag,
                     input logic [3:0] oc);
    logic acc;
    logic pop;
    logic [27:0] e;
    if (!rst) begin
      chk("rst_read", d, 32'(rd), 32'd0);
      chk("rst_rsp_vld", d, 32'(rv), 32'd0);
      chk("rst_occ", d, 32'(oc), 32'd0);
      chk("rst_req_rdy", d, 32'(rdy), 32'd0);
      sbq[d].delete();
      occm[d] = 0;
      pm[d]   = 0;
      held[d] = 1'b0;
      return;
    end
    chk("occ", d, 32'(oc), 32'(occm[d]));
    chk("req_rdy", d, 32'(rdy), 32'(occm[d] < 8));
    acc = req_vld & rdy;
    if (acc) begin
      chk("read_issue", d, 32'(rd), 32'(1 << pm[d]));
      chk("rd_adr", d, 32'(radr), 32'(req_adr));
      sbq[d].push_back({req_tag, memf(req_adr)});
      pm[d] = (pm[d] + 1) % 4;
    end else begin
      chk("read_idle", d, 32'(rd), 32'd0);
    end
    if (held[d]) begin
      chk("hold_vld", d, 32'(rv), 32'd1);
      chk("hold_ent", d, 32'({rtag, rdat}), 32'(hent[d]));
    end
    pop = rv & rsp_rdy;
    if (pop) begin
      if (sbq[d].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp dut%0d got tag %0h data %0h exp none", d, rtag, rdat);
      end else begin
        e = sbq[d].pop_front();
        chk("rsp_ent", d, 32'({rtag, rdat}), 32'(e));
      end
    end
    held[d] = rv & ~rsp_rdy;
    hent[d] = {rtag, rdat};
    occm[d] = occm[d] + int'(acc) - int'(pop);
  endtask

  always @(negedge clk) begin
    mon(0, req_rdy0, read0, rd_adr0[pm[0]], rsp_vld0, rsp_data0, rsp_tag0, occ0);
    mon(1, req_rdy1, read1, rd_adr1[pm[1]], rsp_vld1, rsp_data1, rsp_tag1, occ1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    for (int k = 0; k < 64 && (occ0 != 4'd0 || occ1 != 4'd0); k++) tick();
    chk("drain_occ", 0, 32'(occ0), 32'd0);
    chk("drain_occ", 1, 32'(occ1), 32'd0);
    chk("drain_sb", 0, 32'(sbq[0].size()), 32'd0);
    chk("drain_sb", 1, 32'(sbq[1].size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0;
    int a1;
    rst = 1'b0; req_vld = 1'b0; req_adr = '0; req_tag = '0; rsp_rdy = 1'b0;
    repeat (2) tick();
    req_vld = 1'b1;
    #1;
    chk("rst_hold_rdy", 0, 32'(req_rdy0), 32'd0);
    chk("rst_hold_read", 0, 32'(read0), 32'd0);
    req_vld = 1'b0;
    rst = 1'b1;
    tick();

    // Rotation across the four ports
    rsp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_vld = 1'b1; req_adr = 6'(6'h10 + i); req_tag = 4'(i);
      #1;
      chk("t2_read", 0, 32'(read0), 32'(1 << (i % 4)));
      chk("t2_read", 1, 32'(read1), 32'(1 << (i % 4)));
      chk("t2_rd_adr", 0, 32'(rd_adr0[i % 4]), 32'(6'h10 + i));
      tick();
    end
    chk("t2_rd_adr0_last", 0, 32'(rd_adr0[0]), 32'h14);
    drain();

    // Latency: comb instance responds one cycle after accept, flopped one two cycles after
    req_vld = 1'b1; req_adr = 6'h2A; req_tag = 4'd7;
    #1;
    chk("t3_rdy", 0, 32'(req_rdy0), 32'd1);
    chk("t3_vld_c0", 0, 32'(rsp_vld0), 32'd0);
    chk("t3_vld_c0", 1, 32'(rsp_vld1), 32'd0);
    tick();
    req_vld = 1'b0;
    chk("t3_vld_c1", 0, 32'(rsp_vld0), 32'd1);
    chk("t3_data", 0, 32'(rsp_data0), 32'(memf(6'h2A)));
    chk("t3_tag", 0, 32'(rsp_tag0), 32'd7);
    chk("t3_vld_c1", 1, 32'(rsp_vld1), 32'd0);
    tick();
    chk("t3_vld_c2", 0, 32'(rsp_vld0), 32'd0);
    chk("t3_vld_c2", 1, 32'(rsp_vld1), 32'd1);
    chk("t3_data", 1, 32'(rsp_data1), 32'(memf(6'h2A)));
    chk("t3_tag", 1, 32'(rsp_tag1), 32'd7);
    tick();
    chk("t3_vld_c3", 1, 32'(rsp_vld1), 32'd0);

    // Backpressure: credit stops acceptance at FIFODEP
    rsp_rdy = 1'b0; a0 = 0; a1 = 0;
    for (int i = 0; i < 12; i++) begin
      req_vld = 1'b1; req_adr = 6'(6'h20 + i); req_tag = 4'(i);
      #1;
      if (req_rdy0) a0++;
      if (req_rdy1) a1++;
      tick();
    end
    req_vld = 1'b0;
    chk("t4_accepts", 0, 32'(a0), 32'd8);
    chk("t4_accepts", 1, 32'(a1), 32'd8);
    chk("t4_occ", 0, 32'(occ0), 32'd8);
    chk("t4_rdy", 0, 32'(req_rdy0), 32'd0);
    chk("t4_head", 0, 32'({rsp_tag0, rsp_data0}), 32'({4'd0, memf(6'h20)}));
    chk("t4_head", 1, 32'({rsp_tag1, rsp_data1}), 32'({4'd0, memf(6'h20)}));

    // Full FIFO: one pop frees credit, then accept+pop holds occupancy while pointers wrap
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("t5_rdy", 0, 32'(req_rdy0), 32'd1);
    chk("t5_occ", 0, 32'(occ0), 32'd7);
    chk("t5_occ", 1, 32'(occ1), 32'd7);
    for (int i = 0; i < 4; i++) begin
      req_vld = 1'b1; rsp_rdy = 1'b1; req_adr = 6'(6'h30 + i); req_tag = 4'(12 + i);
      tick();
      chk("t5_occ_hold", 0, 32'(occ0), 32'd7);
      chk("t5_occ_hold", 1, 32'(occ1), 32'd7);
    end
    drain();

    // Reset with requests in flight
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_vld = 1'b1; req_adr = 6'(6'h05 + i); req_tag = 4'(i);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("t1_read", 0, 32'(read0), 32'd0);
    chk("t1_read", 1, 32'(read1), 32'd0);
    chk("t1_vld", 0, 32'(rsp_vld0), 32'd0);
    chk("t1_vld", 1, 32'(rsp_vld1), 32'd0);
    chk("t1_occ", 0, 32'(occ0), 32'd0);
    chk("t1_occ", 1, 32'(occ1), 32'd0);
    tick();
    tick();
    rst = 1'b1; req_adr = 6'h3F; req_tag = 4'd9;
    #1;
    chk("t1_port0", 0, 32'(read0), 32'd1);
    chk("t1_port0", 1, 32'(read1), 32'd1);
    tick();
    drain();

    // Random traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      req_vld = ($urandom_range(0, 3) != 0);
      rsp_rdy = ($urandom_range(0, 2) != 0);
      req_adr = 6'($urandom);
      req_tag = 4'(i);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
